// File: rtl/b1_scfifo_gen_if.sv
// rtl/b1_scfifo_gen_if.sv - producer/consumer bundle for b1_scfifo_gen
// Signals: wrreq_i/data_i (write side), rdreq_i/q_o (read side), status
// flags empty_o/full_o/almost_full_o/almost_empty_o, fill count usedw_o,
// and the ovf_o/udf_o rejection pulses.
// master: drives requests and write data; slave: the FIFO itself.
interface b1_scfifo_gen_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
);
  logic              wrreq_i;
  logic [DWIDTH-1:0] data_i;
  logic              rdreq_i;
  logic [DWIDTH-1:0] q_o;
  logic              empty_o;
  logic              full_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [AWIDTH:0]   usedw_o;
  logic              ovf_o;
  logic              udf_o;

  modport master (
    output wrreq_i, data_i, rdreq_i,
    input  q_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o,
           ovf_o, udf_o
  );

  modport slave (
    input  wrreq_i, data_i, rdreq_i,
    output q_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o,
           ovf_o, udf_o
  );
endinterface

// File: rtl/b1_scfifo_gen.sv
// rtl/b1_scfifo_gen.sv - parametrised single-clock FIFO, normal or show-ahead
// Ports: clk_i (rising edge), rst_n_i (async active-low clear),
// srst_i (sync active-high clear), bus (slave modport of b1_scfifo_gen_if:
// wrreq_i/data_i/rdreq_i in; q_o, empty_o, full_o, almost_full_o,
// almost_empty_o, usedw_o, ovf_o, udf_o out).
module b1_scfifo_gen #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 8,
  parameter int SHOWAHEAD = 0,
  parameter int AF_LEVEL  = 2**AWIDTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           srst_i,
  b1_scfifo_gen_if.slave bus
);
  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] AF_W    = AF_LEVEL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_W    = AE_LEVEL[AWIDTH:0];
  localparam logic            AE_RST  = (AE_LEVEL > 0);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wp, rp;
  logic [AWIDTH:0]   usedw, usedw_next;
  logic [DWIDTH-1:0] q_reg;
  logic              empty_r, full_r, af_r, ae_r, ovf_r, udf_r;
  logic              wr_acc, rd_acc;

  // Acceptance looks only at the registered flags, so a full FIFO rejects a
  // write even when a read frees a slot on the same edge (and vice versa).
  always_comb begin
    wr_acc     = bus.wrreq_i && !full_r;
    rd_acc     = bus.rdreq_i && !empty_r;
    usedw_next = usedw + {{AWIDTH{1'b0}}, wr_acc} - {{AWIDTH{1'b0}}, rd_acc};
  end

  // Storage is never cleared; only pointers and count are.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && !srst_i && wr_acc)
      mem[wp] <= bus.data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp      <= '0;
      rp      <= '0;
      usedw   <= '0;
      q_reg   <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      af_r    <= 1'b0;
      ae_r    <= AE_RST;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else if (srst_i) begin
      wp      <= '0;
      rp      <= '0;
      usedw   <= '0;
      q_reg   <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      af_r    <= 1'b0;
      ae_r    <= AE_RST;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_acc)
        wp <= wp + AWIDTH'(1);
      // q_reg captures the word being consumed: the normal-mode output, and
      // the word show-ahead mode keeps presenting once the FIFO runs dry.
      if (rd_acc) begin
        rp    <= rp + AWIDTH'(1);
        q_reg <= mem[rp];
      end
      usedw   <= usedw_next;
      empty_r <= (usedw_next == '0);
      full_r  <= (usedw_next == DEPTH_W);
      af_r    <= (usedw_next >= AF_W);
      ae_r    <= (usedw_next < AE_W);
      ovf_r   <= bus.wrreq_i && full_r;
      udf_r   <= bus.rdreq_i && empty_r;
    end
  end

  always_comb begin
    bus.q_o = q_reg;
    if (SHOWAHEAD != 0 && !empty_r)
      bus.q_o = mem[rp];
  end

  assign bus.empty_o        = empty_r;
  assign bus.full_o         = full_r;
  assign bus.almost_full_o  = af_r;
  assign bus.almost_empty_o = ae_r;
  assign bus.usedw_o        = usedw;
  assign bus.ovf_o          = ovf_r;
  assign bus.udf_o          = udf_r;
endmodule

// File: tb/tb_b1_scfifo_gen.sv
// tb/tb_b1_scfifo_gen.sv - self-checking bench for b1_scfifo_gen
// dut_a: AWIDTH=8 normal mode; dut_b: AWIDTH=3 show-ahead mode.
module tb_b1_scfifo_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, srst_a, srst_b;
  int   total = 0;
  int   bad   = 0;

  b1_scfifo_gen_if #(.DWIDTH(8), .AWIDTH(8)) ifa ();
  b1_scfifo_gen_if #(.DWIDTH(8), .AWIDTH(3)) ifb ();

  b1_scfifo_gen #(.DWIDTH(8), .AWIDTH(8), .SHOWAHEAD(0), .AF_LEVEL(254), .AE_LEVEL(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .srst_i(srst_a), .bus(ifa));
  b1_scfifo_gen #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD(1), .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .srst_i(srst_b), .bus(ifb));

  // scoreboard / model state
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  int         cnt_a, cnt_b;
  logic [7:0] last_a, last_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic eo, input logic eu);
    chk({tag, ".usedw"}, 32'(ifa.usedw_o), 32'(cnt_a));
    chk({tag, ".empty"}, 32'(ifa.empty_o), 32'(cnt_a == 0));
    chk({tag, ".full"},  32'(ifa.full_o),  32'(cnt_a == 256));
    chk({tag, ".af"},    32'(ifa.almost_full_o),  32'(cnt_a >= 254));
    chk({tag, ".ae"},    32'(ifa.almost_empty_o), 32'(cnt_a < 2));
    chk({tag, ".ovf"},   32'(ifa.ovf_o), 32'(eo));
    chk({tag, ".udf"},   32'(ifa.udf_o), 32'(eu));
    chk({tag, ".q"},     32'(ifa.q_o),   32'(last_a));
  endtask

  task automatic chk_b(input string tag, input logic eo, input logic eu);
    logic [7:0] eq;
    eq = (cnt_b > 0) ? sb_b[0] : last_b;
    chk({tag, ".usedw"}, 32'(ifb.usedw_o), 32'(cnt_b));
    chk({tag, ".empty"}, 32'(ifb.empty_o), 32'(cnt_b == 0));
    chk({tag, ".full"},  32'(ifb.full_o),  32'(cnt_b == 8));
    chk({tag, ".af"},    32'(ifb.almost_full_o),  32'(cnt_b >= 6));
    chk({tag, ".ae"},    32'(ifb.almost_empty_o), 32'(cnt_b < 2));
    chk({tag, ".ovf"},   32'(ifb.ovf_o), 32'(eo));
    chk({tag, ".udf"},   32'(ifb.udf_o), 32'(eu));
    chk({tag, ".q"},     32'(ifb.q_o),   32'(eq));
  endtask

  // One cycle on dut_a: drive, clock, update model, compare everything.
  task automatic cyc_a(input logic w, input logic r, input logic [7:0] d, input string tag);
    logic wa, ra;
    wa = w && (cnt_a != 256);
    ra = r && (cnt_a != 0);
    ifa.wrreq_i = w;
    ifa.rdreq_i = r;
    ifa.data_i  = d;
    step();
    ifa.wrreq_i = 1'b0;
    ifa.rdreq_i = 1'b0;
    if (ra) last_a = sb_a.pop_front();
    if (wa) sb_a.push_back(d);
    cnt_a = cnt_a + int'(wa) - int'(ra);
    chk_a(tag, w && !wa, r && !ra);
  endtask

  task automatic cyc_b(input logic w, input logic r, input logic [7:0] d, input string tag);
    logic wa, ra;
    wa = w && (cnt_b != 8);
    ra = r && (cnt_b != 0);
    ifb.wrreq_i = w;
    ifb.rdreq_i = r;
    ifb.data_i  = d;
    step();
    ifb.wrreq_i = 1'b0;
    ifb.rdreq_i = 1'b0;
    if (ra) last_b = sb_b.pop_front();
    if (wa) sb_b.push_back(d);
    cnt_b = cnt_b + int'(wa) - int'(ra);
    chk_b(tag, w && !wa, r && !ra);
  endtask

  task automatic model_reset_a();
    sb_a.delete();
    cnt_a  = 0;
    last_a = 8'h00;
  endtask

  task automatic model_reset_b();
    sb_b.delete();
    cnt_b  = 0;
    last_b = 8'h00;
  endtask

  initial begin
    rst_n  = 1'b0;
    srst_a = 1'b0;
    srst_b = 1'b0;
    ifa.wrreq_i = 1'b0; ifa.rdreq_i = 1'b0; ifa.data_i = 8'h00;
    ifb.wrreq_i = 1'b0; ifb.rdreq_i = 1'b0; ifb.data_i = 8'h00;
    model_reset_a();
    model_reset_b();

    #12;
    chk_a("rst_a", 1'b0, 1'b0);
    chk_b("rst_b", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // fill to full, then one rejected write
    for (int i = 0; i < 256; i++) cyc_a(1'b1, 1'b0, 8'(i), "fill");
    chk("fill.full_const", 32'(ifa.full_o), 32'd1);
    chk("fill.usedw_const", 32'(ifa.usedw_o), 32'd256);
    cyc_a(1'b1, 1'b0, 8'h77, "ovf");
    chk("ovf.pulse_const", 32'(ifa.ovf_o), 32'd1);
    cyc_a(1'b0, 1'b0, 8'h00, "ovf_end");

    // drain, then one rejected read
    for (int i = 0; i < 256; i++) cyc_a(1'b0, 1'b1, 8'h00, "drain");
    chk("drain.empty_const", 32'(ifa.empty_o), 32'd1);
    cyc_a(1'b0, 1'b1, 8'h00, "udf");
    chk("udf.pulse_const", 32'(ifa.udf_o), 32'd1);
    chk("udf.qhold_const", 32'(ifa.q_o), 32'hff);
    cyc_a(1'b0, 1'b0, 8'h00, "udf_end");

    // steady simultaneous read+write at usedw=5
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b0, 8'(8'h10 + i), "pre5");
    for (int i = 0; i < 10; i++) begin
      cyc_a(1'b1, 1'b1, 8'(8'h20 + i), "rw5");
      chk("rw5.usedw_const", 32'(ifa.usedw_o), 32'd5);
    end
    for (int i = 0; i < 5; i++) cyc_a(1'b0, 1'b1, 8'h00, "post5");

    // simultaneous at full
    for (int i = 0; i < 256; i++) cyc_a(1'b1, 1'b0, 8'(i) ^ 8'h5a, "fill2");
    cyc_a(1'b1, 1'b1, 8'hee, "rwfull");
    chk("rwfull.usedw_const", 32'(ifa.usedw_o), 32'd255);
    chk("rwfull.ovf_const", 32'(ifa.ovf_o), 32'd1);
    for (int i = 0; i < 255; i++) cyc_a(1'b0, 1'b1, 8'h00, "drain2");

    // simultaneous at empty
    cyc_a(1'b1, 1'b1, 8'h3c, "rwempty");
    chk("rwempty.usedw_const", 32'(ifa.usedw_o), 32'd1);
    chk("rwempty.udf_const", 32'(ifa.udf_o), 32'd1);
    cyc_a(1'b0, 1'b1, 8'h00, "rd3c");
    chk("rd3c.q_const", 32'(ifa.q_o), 32'h3c);

    // async reset mid-operation, checked before the next clock edge
    for (int i = 0; i < 100; i++) cyc_a(1'b1, 1'b0, 8'(i + 1), "fill100");
    chk("fill100.usedw_const", 32'(ifa.usedw_o), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset_a();
    model_reset_b();
    chk_a("arst_a", 1'b0, 1'b0);
    chk("arst.q_const", 32'(ifa.q_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sync reset with a concurrent write at usedw=7
    for (int i = 0; i < 7; i++) cyc_a(1'b1, 1'b0, 8'(8'h60 + i), "fill7");
    srst_a = 1'b1;
    ifa.wrreq_i = 1'b1;
    ifa.data_i  = 8'h99;
    step();
    srst_a = 1'b0;
    ifa.wrreq_i = 1'b0;
    model_reset_a();
    chk_a("srst", 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 8'h42, "post_srst_wr");
    cyc_a(1'b0, 1'b1, 8'h00, "post_srst_rd");
    chk("post_srst.q_const", 32'(ifa.q_o), 32'h42);

    // show-ahead: word visible as empty falls, held after the last read
    cyc_b(1'b1, 1'b0, 8'ha5, "sa_wr");
    chk("sa_wr.empty_const", 32'(ifb.empty_o), 32'd0);
    chk("sa_wr.q_const", 32'(ifb.q_o), 32'ha5);
    cyc_b(1'b0, 1'b1, 8'h00, "sa_rd");
    chk("sa_rd.empty_const", 32'(ifb.empty_o), 32'd1);
    chk("sa_rd.q_const", 32'(ifb.q_o), 32'ha5);

    // random wrap-around traffic on the 8-deep show-ahead FIFO
    for (int i = 0; i < 1000; i++)
      cyc_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/b1_scfifo_gen.md
# b1_scfifo_gen

Parametrised single-clock FIFO in native RTL, the successor to the vendor-IP FIFO wrapper. It adds a full power-of-two depth, runtime-independent normal/show-ahead mode selected by parameter, programmable almost-full and almost-empty flags, and overflow/underflow error pulses. It sits between a producer and a consumer in the same clock domain. It is portable to any simulator or synthesis flow.

## Interface
- DWIDTH, 8: data word width, ≥1.
- AWIDTH, 8: address width; depth = 2**AWIDTH words, AWIDTH ≥ 1.
- SHOWAHEAD, 0: 0 = normal mode (q after read); 1 = show-ahead mode (head word presented before read).
- AF_LEVEL, 2**AWIDTH-2: almost_full_o threshold, range 1..2**AWIDTH.
- AE_LEVEL, 2: almost_empty_o threshold, range 0..2**AWIDTH.
- clk_i  in  1  single clock; all logic is rising-edge.
- rst_n_i  in  1  asynchronous active-low reset.
- srst_i  in  1  synchronous clear, active-high.
- wrreq_i  in  1  write request.
- data_i  in  DWIDTH  write data.
- rdreq_i  in  1  read request.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  no words stored.
- full_o  out  1  2**AWIDTH words stored.
- almost_full_o  out  1  usedw_o ≥ AF_LEVEL.
- almost_empty_o  out  1  usedw_o < AE_LEVEL.
- usedw_o  out  AWIDTH+1  stored word count, 0..2**AWIDTH.
- ovf_o  out  1  one-cycle pulse: write rejected.
- udf_o  out  1  one-cycle pulse: read rejected.

## Operation
- Storage: 2**AWIDTH x DWIDTH array. Write pointer wp and read pointer rp are AWIDTH bits and wrap modulo 2**AWIDTH. Count is held in a separate AWIDTH+1-bit register.
- Write accepted iff wrreq_i && !full_o. If accepted, mem[wp] <= data_i and wp increments.
- Read accepted iff rdreq_i && !empty_o. If accepted, rp increments.
- Acceptance is evaluated on the registered flags, before this edge's update.
- Full FIFO with simultaneous wrreq_i+rdreq_i: the read is accepted and the write is rejected. ovf_o pulses and usedw decrements by 1.
- Empty FIFO with simultaneous wrreq_i+rdreq_i: the write is accepted and the read is rejected. udf_o pulses and usedw increments by 1.
- Otherwise, simultaneous accepted read and write: usedw is unchanged and both pointers advance.
- Rejected write: no state change, ovf_o=1 for the next cycle. Rejected read: no state change, udf_o=1 for the next cycle.
- Count arithmetic: usedw_next = usedw + wr_acc - rd_acc. It never wraps.
- Flags are all registered and derived from usedw_next:
  - empty = (usedw_next==0)
  - full = (usedw_next==2**AWIDTH)
  - almost_full = (usedw_next ≥ AF_LEVEL)
  - almost_empty = (usedw_next < AE_LEVEL)
- Normal mode (SHOWAHEAD=0): q_o is registered. It loads mem[rp] on an accepted read and otherwise holds its value.
- Show-ahead mode (SHOWAHEAD=1): q_o = mem[rp] whenever !empty_o. When empty_o=1, q_o holds the last presented word. An accepted read advances q_o to the next word.
- srst_i (sync) has priority over rd/wr in that cycle:
  - wp, rp and usedw are zeroed, flags go to reset values, and q_o is cleared to 0.
  - ovf_o and udf_o are 0.
  - Memory contents are not cleared.
- rst_n_i (async) produces the same values as srst_i, applied immediately and independent of clk_i.

## Timing
- Reset values, under both rst_n_i=0 and srst_i:
  - empty_o=1, full_o=0, usedw_o=0, q_o=0
  - almost_full_o=0
  - almost_empty_o=(AE_LEVEL>0)
  - ovf_o=0, udf_o=0
- Write at edge N: usedw_o, empty_o, full_o and almost flags reflect it after edge N.
- Show-ahead: after a write into an empty FIFO at edge N, q_o shows that word in the same cycle empty_o falls.
- Normal-mode read latency is 1: rdreq_i accepted at edge N gives q_o valid after edge N, and the value holds until the next accepted read.
- Show-ahead read latency is 0: q_o is valid while !empty_o, and rdreq_i acknowledges the word.
- Read-during-write at the same address only occurs with usedw=0 (read rejected) or usedw=2**AWIDTH (write rejected). No memory bypass is needed.
- Sustained throughput is one write and one read per cycle.
- rst_n_i deassertion is synchronised externally. The first write is accepted on the first edge after deassertion.

## Test plan
- Reset, then fill: write 0x00..0xFF (AWIDTH=8) on consecutive cycles. Required response:
  - full_o=1 after the 256th write, usedw_o=256.
  - almost_full_o rises when usedw_o reaches 254.
  - A 257th write produces ovf_o pulse and no usedw change.
- Drain in normal mode: 256 consecutive reads. Required response:
  - q_o = 0x00..0xFF, each one cycle after its rdreq_i.
  - empty_o=1 after the last read.
  - An extra read produces udf_o pulse and q_o holds 0xFF.
- Show-ahead mode: write 0xA5 into an empty FIFO. Required response:
  - After the edge, empty_o=0 and q_o=0xA5 in the same cycle.
  - A read gives empty_o=1 and q_o still 0xA5.
- Simultaneous read+write:
  - At usedw=5 for 10 cycles: usedw_o stays 5 and data order is preserved.
  - At full: usedw goes 256→255 with ovf_o pulse.
  - At empty: usedw goes 0→1 with udf_o pulse.
- Wrap-around: 1000 random cycles of rd/wr, AWIDTH=3, against a scoreboard. Required response: no data mismatch, and flags are consistent with usedw_o every cycle.
- Reset mid-operation:
  - rst_n_i=0 asynchronously at usedw=100: all outputs go to reset values before the next edge.
  - srst_i with wrreq_i at usedw=7: usedw_o=0 next cycle and the write is dropped.
